// File: rtl/id_token_fsm_if.sv
// Character-stream bus for the identifier/number token recogniser.
// master drives characters in, slave returns the per-character classification results.
interface id_token_fsm_if #(
    parameter int CHAR_W = 8,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16
);
    logic [CHAR_W-1:0] char_in;
    logic              valid;
    logic [1:0]        mode;
    logic              match;
    logic [LEN_W-1:0]  tok_len;
    logic [CNT_W-1:0]  match_cnt;
    logic              overflow;

    modport master (
        output char_in, valid, mode,
        input  match, tok_len, match_cnt, overflow
    );

    modport slave (
        input  char_in, valid, mode,
        output match, tok_len, match_cnt, overflow
    );
endinterface

// File: rtl/id_token_fsm.sv
// Per-character token recogniser with three selectable patterns.
// Tracks token length, a sticky overflow flag and a count of matched tokens.
module id_token_fsm #(
    parameter int CHAR_W = 8,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           reset,
    id_token_fsm_if.slave bus
);
    typedef enum logic [1:0] {C_L, C_D, C_U, C_O} cls_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ALPHA, S_DIGIT, S_IDENT, S_NUM, S_SKIP
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [1:0]        mode_q;
    logic              match_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;

    logic [6:0] code;
    logic       high;
    cls_t       cls;
    logic [1:0] em;
    state_t     cur;
    state_t     nxt;
    logic       cur_hit;
    logic       nxt_hit;
    logic       restart;
    logic       count_exit;

    // Codes above 127 are always "other"; underscore only counts in mode 1.
    always_comb begin
        code = bus.char_in[6:0];
        high = (bus.char_in >> 7) != '0;
        cls  = C_O;
        if (!high) begin
            if ((code >= 7'd65 && code <= 7'd90) ||
                (code >= 7'd97 && code <= 7'd122))
                cls = C_L;
            else if (code >= 7'd48 && code <= 7'd57)
                cls = C_D;
            else if (code == 7'd95 && bus.mode == 2'd1)
                cls = C_U;
        end
    end

    // A mode change abandons the current token and evaluates from IDLE.
    always_comb begin
        em  = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
        cur = (bus.mode != mode_q) ? S_IDLE : state;
        nxt = S_IDLE;
        case (em)
            2'd1: begin
                case (cur)
                    S_IDLE: begin
                        if (cls == C_L || cls == C_U) nxt = S_IDENT;
                        else if (cls == C_D)          nxt = S_SKIP;
                    end
                    S_IDENT: if (cls != C_O) nxt = S_IDENT;
                    S_SKIP:  if (cls != C_O) nxt = S_SKIP;
                    default: nxt = S_IDLE;
                endcase
            end
            2'd2: begin
                case (cur)
                    S_IDLE, S_NUM: begin
                        if (cls == C_D)      nxt = S_NUM;
                        else if (cls == C_L) nxt = S_SKIP;
                    end
                    S_SKIP: if (cls == C_L || cls == C_D) nxt = S_SKIP;
                    default: nxt = S_IDLE;
                endcase
            end
            default: begin
                case (cur)
                    S_IDLE: if (cls == C_L) nxt = S_ALPHA;
                    S_ALPHA: begin
                        if (cls == C_L)      nxt = S_ALPHA;
                        else if (cls == C_D) nxt = S_DIGIT;
                    end
                    S_DIGIT: begin
                        if (cls == C_D)      nxt = S_DIGIT;
                        else if (cls == C_L) nxt = S_ALPHA;
                    end
                    default: nxt = S_IDLE;
                endcase
            end
        endcase
        cur_hit = (cur == S_DIGIT) || (cur == S_IDENT) || (cur == S_NUM);
        nxt_hit = (nxt == S_DIGIT) || (nxt == S_IDENT) || (nxt == S_NUM);
        restart = (em == 2'd0) && (cur == S_DIGIT) && (nxt == S_ALPHA);
        count_exit = (cls == C_O) && cur_hit && (nxt == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            mode_q  <= 2'd0;
            match_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            match_q <= bus.valid && nxt_hit;
            if (bus.valid) begin
                state  <= nxt;
                mode_q <= bus.mode;
                if (nxt == S_IDLE)
                    len_q <= '0;
                else if (cur == S_IDLE || restart)
                    len_q <= LEN_ONE;
                else if (len_q == LEN_MAX)
                    ovf_q <= 1'b1;
                else
                    len_q <= len_q + LEN_ONE;
                if (count_exit)
                    cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.match     = match_q;
    assign bus.tok_len   = len_q;
    assign bus.match_cnt = cnt_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_id_token_fsm.sv
// Scoreboard bench for id_token_fsm: a default-width instance (a) and a
// narrow instance (b, LEN_W=3, CNT_W=2) for saturation and counter wrap.
module tb_id_token_fsm;
    typedef struct packed {
        logic        m;
        logic [5:0]  len;
        logic [15:0] cnt;
        logic        ov;
    } res_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    res_t sb[$];

    id_token_fsm_if #(.CHAR_W(8), .LEN_W(6), .CNT_W(16)) ifa ();
    id_token_fsm_if #(.CHAR_W(8), .LEN_W(3), .CNT_W(2))  ifb ();

    id_token_fsm #(.CHAR_W(8), .LEN_W(6), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    id_token_fsm #(.CHAR_W(8), .LEN_W(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t mk(bit m, int l, int c, bit ov);
        res_t r;
        r.m   = m;
        r.len = 6'(l);
        r.cnt = 16'(c);
        r.ov  = ov;
        return r;
    endfunction

    function automatic res_t obs(bit sel);
        res_t r;
        if (sel) begin
            r.m   = ifb.match;
            r.len = {3'b000, ifb.tok_len};
            r.cnt = {14'd0, ifb.match_cnt};
            r.ov  = ifb.overflow;
        end else begin
            r.m   = ifa.match;
            r.len = ifa.tok_len;
            r.cnt = ifa.match_cnt;
            r.ov  = ifa.overflow;
        end
        return r;
    endfunction

    task automatic drive(bit sel, byte ch, bit v, logic [1:0] md, res_t e);
        @(negedge clk);
        ifa.valid = 1'b0;
        ifb.valid = 1'b0;
        if (sel) begin
            ifb.char_in = ch;
            ifb.valid   = v;
            ifb.mode    = md;
        end else begin
            ifa.char_in = ch;
            ifa.valid   = v;
            ifa.mode    = md;
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifa.valid = 1'b0;
        ifb.valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        res_t o;
        @(negedge clk);
        reset = 1'b1;
        ifa.valid = 1'b0;
        ifb.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k[0]);
            n_checks++;
            if (o !== mk(0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL reset inst%0d: got m=%b len=%0d cnt=%0d ov=%b, want all 0",
                         k, o.m, o.len, o.cnt, o.ov);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mode0();
        string s = "ab12 a1b2 ";
        bit m[10] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 0};
        int l[10] = '{1, 2, 3, 4, 0, 1, 2, 1, 2, 0};
        int c[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
        res_t e, o;
        for (int i = 0; i < 10; i++) begin
            drive(0, s[i], 1, 2'd0, mk(m[i], l[i], c[i], 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs(0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode0 step %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                         i, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
            end
        end
    endtask

    task automatic test_mode1();
        string s = "_x9 1a ";
        bit m[7] = '{1, 1, 1, 0, 0, 0, 0};
        int l[7] = '{1, 2, 3, 0, 1, 2, 0};
        int c[7] = '{2, 2, 2, 3, 3, 3, 3};
        res_t e, o;
        for (int i = 0; i < 7; i++) begin
            drive(0, s[i], 1, 2'd1, mk(m[i], l[i], c[i], 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs(0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode1 step %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                         i, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
            end
        end
    endtask

    task automatic test_mode2();
        string s = "42a7 9 ";
        bit m[7] = '{1, 1, 0, 0, 0, 1, 0};
        int l[7] = '{1, 2, 3, 4, 0, 1, 0};
        int c[7] = '{3, 3, 3, 3, 3, 3, 4};
        res_t e, o;
        for (int i = 0; i < 7; i++) begin
            drive(0, s[i], 1, 2'd2, mk(m[i], l[i], c[i], 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs(0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode2 step %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                         i, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
            end
        end
    endtask

    task automatic test_mode_switch();
        string s = "a13 ";
        logic [1:0] md[4] = '{2'd0, 2'd0, 2'd2, 2'd2};
        bit m[4] = '{0, 1, 1, 0};
        int l[4] = '{1, 2, 1, 0};
        int c[4] = '{4, 4, 4, 5};
        res_t e, o;
        for (int i = 0; i < 4; i++) begin
            drive(0, s[i], 1, md[i], mk(m[i], l[i], c[i], 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs(0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode_switch step %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                         i, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
            end
        end
    endtask

    task automatic test_reset_mid();
        string s = "abc";
        res_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive(0, s[i], 1, 2'd1, mk(1, i + 1, 5, 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs(0);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid token step %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                         i, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
            end
        end
        @(negedge clk);
        ifa.valid = 1'b0;
        reset = 1'b1;
        sb.push_back(mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = obs(0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid after reset: got m=%b len=%0d cnt=%0d ov=%b, want all 0",
                     o.m, o.len, o.cnt, o.ov);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(0, " ", 1, 2'd1, mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = obs(0);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid space: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                     o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
        end
    endtask

    task automatic test_saturation();
        res_t e, o;
        int   len;
        bit   ov;
        for (int j = 1; j <= 9; j++) begin
            len = (j > 7) ? 7 : j;
            ov  = (j >= 8);
            for (int g = 0; g < 2; g++) begin
                if (g == 1 && j == 9) break;
                drive(1, "q", (g == 0), 2'd1, mk((g == 0), len, 0, ov));
                @(posedge clk);
                #1;
                e = sb.pop_front();
                o = obs(1);
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL saturation letter %0d gap %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                             j, g, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
                end
            end
        end
        drive(1, " ", 1, 2'd1, mk(0, 0, 1, 1));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = obs(1);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL saturation space: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                     o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
        end
    endtask

    task automatic test_wrap();
        int   c[5] = '{1, 2, 3, 0, 1};
        int   prev;
        res_t e, o;
        do_reset();
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            for (int h = 0; h < 2; h++) begin
                if (h == 0) drive(1, "7", 1, 2'd2, mk(1, 1, prev, 0));
                else        drive(1, " ", 1, 2'd2, mk(0, 0, c[k], 0));
                @(posedge clk);
                #1;
                e = sb.pop_front();
                o = obs(1);
                n_checks++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL wrap token %0d half %0d: got m=%b len=%0d cnt=%0d ov=%b, want m=%b len=%0d cnt=%0d ov=%b",
                             k, h, o.m, o.len, o.cnt, o.ov, e.m, e.len, e.cnt, e.ov);
                end
            end
            prev = c[k];
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        ifa.char_in = 8'd0;
        ifa.valid   = 1'b0;
        ifa.mode    = 2'd0;
        ifb.char_in = 8'd0;
        ifb.valid   = 1'b0;
        ifb.mode    = 2'd0;
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2();
        test_mode_switch();
        test_reset_mid();
        test_saturation();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_token_fsm.md
# id_token_fsm

Parametrised successor to the single-pattern identifier recogniser. Consumes one character per valid cycle and classifies it as letter, digit, underscore or other. A per-token state machine then reports a registered per-character match flag, the running token length, a sticky length-overflow flag and a count of completed matched tokens. It has three selectable patterns and sits in the lexer front end between the character source and token bookkeeping.

## Interface
- CHAR_W, 8: character width; must be ≥ 7. Only codes 0–127 are ever non-"other".
- LEN_W, 6: width of the token length counter.
- CNT_W, 16: width of the matched-token counter.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- char_in  in  CHAR_W  input character code
- valid  in  1  char_in is consumed on this edge
- mode  in  2  0 = letters⁺digits⁺ (legacy pattern), 1 = C identifier, 2 = unsigned decimal, 3 = treated as 0
- match  out  1  current token matches after the last consumed char
- tok_len  out  LEN_W  length of the current token, saturating
- match_cnt  out  CNT_W  completed matched tokens, wraps
- overflow  out  1  sticky: tok_len saturated while the token continued

One clock; reset is synchronous and active-high (ports clk, reset).

## Operation
- Character classes:
  - L: 65–90 or 97–122
  - D: 48–57
  - U: 95
  - O: everything else, including codes ≥ 128
  - U is treated as O in modes 0 and 2.
- States: IDLE, ALPHA, DIGIT, IDENT, NUM, SKIP. Match states are DIGIT, IDENT and NUM.
- Mode 0 transitions:
  - IDLE: L→ALPHA, D/O→IDLE
  - ALPHA: L→ALPHA, D→DIGIT, O→IDLE
  - DIGIT: D→DIGIT, L→ALPHA (starts a new token), O→IDLE
- Mode 1 transitions:
  - IDLE: L/U→IDENT, D→SKIP, O→IDLE
  - IDENT: L/D/U→IDENT, O→IDLE
  - SKIP: L/D/U→SKIP, O→IDLE
- Mode 2 transitions:
  - IDLE: D→NUM, L→SKIP, O→IDLE
  - NUM: D→NUM, L→SKIP, O→IDLE
  - SKIP: L/D→SKIP, O→IDLE
- Mode latch:
  - mode is registered as mode_q on every consumed char.
  - If valid and mode ≠ mode_q, the FSM evaluates that char from IDLE under the new mode.
  - No count increment occurs for the abandoned token.
- tok_len:
  - Any transition into IDLE loads 0.
  - Leaving IDLE, or the mode-0 DIGIT→ALPHA token restart, loads 1.
  - Otherwise a non-IDLE→non-IDLE transition increments it, saturating at 2^LEN_W−1.
  - An increment attempted at saturation sets overflow.
  - overflow clears only on reset.
- match_cnt: increments by 1 (mod 2^CNT_W) when a consumed O-class char moves the FSM from a match state to IDLE. No other exit counts.
- match: 1 in the cycle after a consumed char that leaves the FSM in a match state, otherwise 0. It is a per-character pulse.

## Timing
- All outputs are registered. Latency is 1 cycle from the consuming edge to the outputs.
- With valid=0: state, tok_len, match_cnt, overflow and mode_q hold; match is 0.
- Back-to-back valid chars are processed at 1 per cycle with no bubbles.
- Reset has priority over valid. The next edge yields:
  - state=IDLE, mode_q=0
  - match=0, tok_len=0, match_cnt=0, overflow=0
- Reset mid-token discards the token with no count increment.
- The first char after reset is evaluated from IDLE.
- Count wrap: match_cnt at all-ones plus one counted exit gives 0. Nothing else is affected.

## Test plan
- Mode 0: stream "ab12 " with valid held high. Cycle by cycle after each char:
  - match 0,0,1,1,0
  - tok_len 1,2,3,4,0
  - match_cnt 0→1 after the space
  - Then stream "a1b2 ": match 0,1,0,1,0; tok_len 1,2,1,2,0; match_cnt 1→2.
- Mode 1: stream "_x9 1a ".
  - match 1,1,1,0,0,0,0
  - tok_len 1,2,3,0,1,2,0
  - match_cnt increments only after the first space, ending at 1.
- Mode 2: stream "42a7 9 ".
  - match 1,1,0,0,0,1,0
  - match_cnt ends at 1 ("42a7" is not counted; "9" is)
- Saturation and gaps, with LEN_W=3, mode 1: 9 letters with valid toggled 1,0,1,0,…
  - tok_len 1..7, then held at 7
  - overflow rises after the 8th letter
  - match is 0 in every valid=0 cycle and 1 otherwise
  - A following space gives tok_len 0 with overflow still 1.
- Mode switch mid-token: mode 0 "a1", then mode 2 "3 ".
  - The 3 is evaluated from IDLE → NUM, giving match 1 and tok_len 1.
  - The space gives match_cnt +1 (one increment in total).
- Reset mid-token: mode 1 "abc", assert reset for 1 cycle, then " ".
  - All outputs are 0 after reset.
  - The space leaves match_cnt at 0.
- Counter wrap, with CNT_W=2: 5 × "7 " in mode 2 gives match_cnt 1,2,3,0,1.
